// File: rtl/vram_text_fetch.sv
// Text-row fetcher: copies one row of character codes from text VRAM into a line
// buffer and serves per-column lookups. Define VRAM_TEXT_FETCH_SCROLL_EN for vertical scroll.
module vram_text_fetch #(
    parameter int COLS   = 60,
    parameter int ROWS   = 17,
    parameter int ADDR_W = 10
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_line_req,
    input  logic [4:0]        i_row,
`ifdef VRAM_TEXT_FETCH_SCROLL_EN
    input  logic [4:0]        i_scroll_row,
`endif
    output logic              o_busy,
    output logic              o_line_ready,
    output logic              o_vram_ce,
    output logic [ADDR_W-1:0] o_vram_addr,
    input  logic [7:0]        i_vram_data,
    input  logic [5:0]        i_col,
    output logic [7:0]        o_char_code
);

    localparam logic [6:0] COLS_V = 7'(COLS);
    localparam logic [5:0] ROWS_V = 6'(ROWS);
    localparam logic [7:0] BLANK  = 8'h20;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t            r_state, w_state_nxt;
    logic              r_busy, r_line_ready, r_vram_ce, r_blank;
    logic [ADDR_W-1:0] r_vram_addr, r_base, w_base;
    logic [6:0]        r_i;
    logic              r_iss_vld, r_d1_vld;
    logic [5:0]        r_iss_idx, r_d1_idx;
    logic [7:0]        r_char;
    logic [7:0]        r_buf [64];
    logic [5:0]        w_eff_row;
    logic              w_blank_req;

    // Blanking is decided on the raw row, before any scroll offset.
    assign w_blank_req = ({1'b0, i_row} >= ROWS_V);

`ifdef VRAM_TEXT_FETCH_SCROLL_EN
    logic [5:0] w_scroll, w_row_sum;
    assign w_scroll  = ({1'b0, i_scroll_row} < ROWS_V) ? {1'b0, i_scroll_row} : 6'd0;
    assign w_row_sum = {1'b0, i_row} + w_scroll;
    assign w_eff_row = (w_row_sum >= ROWS_V) ? w_row_sum - ROWS_V : w_row_sum;
`else
    assign w_eff_row = {1'b0, i_row};
`endif

    // row*COLS as a sum of shifted copies, one per set bit of COLS.
    always_comb begin
        w_base = '0;
        for (int b = 0; b < 7; b++) begin
            if (COLS_V[b])
                w_base = w_base + (ADDR_W'(w_eff_row) << b);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_line_req) w_state_nxt = FETCH;
            FETCH:   if (r_i == COLS_V) w_state_nxt = DRAIN;
            DRAIN:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_busy       <= 1'b0;
            r_line_ready <= 1'b0;
            r_vram_ce    <= 1'b0;
            r_vram_addr  <= '0;
            r_base       <= '0;
            r_blank      <= 1'b0;
            r_i          <= '0;
            r_iss_vld    <= 1'b0;
            r_iss_idx    <= '0;
            r_d1_vld     <= 1'b0;
            r_d1_idx     <= '0;
            r_char       <= BLANK;
            for (int k = 0; k < 64; k++) r_buf[k] <= BLANK;
        end else begin
            r_line_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_line_req) begin
                        r_base      <= w_base;
                        r_blank     <= w_blank_req;
                        r_busy      <= 1'b1;
                        r_iss_vld   <= 1'b1;
                        r_iss_idx   <= '0;
                        r_i         <= 7'd1;
                        r_vram_ce   <= ~w_blank_req;
                        r_vram_addr <= w_blank_req ? '0 : w_base;
                    end
                end
                FETCH: begin
                    if (r_i == COLS_V) begin
                        r_iss_vld <= 1'b0;
                        r_vram_ce <= 1'b0;
                    end else begin
                        r_iss_idx <= r_i[5:0];
                        r_i       <= r_i + 7'd1;
                        if (!r_blank)
                            r_vram_addr <= r_base + ADDR_W'(r_i);
                    end
                end
                DRAIN: begin
                    r_busy       <= 1'b0;
                    r_line_ready <= 1'b1;
                end
                default: ;
            endcase

            // Issue -> VRAM register -> capture: two-cycle return path.
            r_d1_vld <= r_iss_vld;
            r_d1_idx <= r_iss_idx;
            if (r_d1_vld)
                r_buf[r_d1_idx] <= r_blank ? BLANK : i_vram_data;

            r_char <= ({1'b0, i_col} < COLS_V) ? r_buf[i_col] : BLANK;
        end
    end

    assign o_busy       = r_busy;
    assign o_line_ready = r_line_ready;
    assign o_vram_ce    = r_vram_ce;
    assign o_vram_addr  = r_vram_addr;
    assign o_char_code  = r_char;

endmodule

// File: tb/tb_vram_text_fetch.sv
// Directed + randomized bench for vram_text_fetch with a VRAM model and a row-level reference.
module tb_vram_text_fetch;
    localparam int COLS = 60;
    localparam int ROWS = 17;
    localparam int AW   = 10;

    logic          clk = 1'b0, reset = 1'b1, line_req = 1'b0;
    logic [4:0]    row = '0;
`ifdef VRAM_TEXT_FETCH_SCROLL_EN
    logic [4:0]    scroll_row = '0;
`endif
    logic          busy, line_ready, vram_ce;
    logic [AW-1:0] vram_addr;
    logic [7:0]    vram_data = '0;
    logic [5:0]    col = '0;
    logic [7:0]    char_code;

    vram_text_fetch #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(AW)) dut (
        .i_clk(clk), .i_reset(reset), .i_line_req(line_req), .i_row(row),
`ifdef VRAM_TEXT_FETCH_SCROLL_EN
        .i_scroll_row(scroll_row),
`endif
        .o_busy(busy), .o_line_ready(line_ready), .o_vram_ce(vram_ce),
        .o_vram_addr(vram_addr), .i_vram_data(vram_data), .i_col(col),
        .o_char_code(char_code));

    always #5 clk = ~clk;

    logic [7:0] mem [1024];
    always @(posedge clk) if (vram_ce) vram_data <= mem[vram_addr];

    int cyc = 0, busy_cnt = 0, lr_cnt = 0, lr_cyc = 0;
    int addr_q[$];
    always @(posedge clk) begin
        #1;
        cyc++;
        if (busy) busy_cnt++;
        if (line_ready) begin lr_cnt++; lr_cyc = cyc; end
        if (vram_ce) addr_q.push_back(int'(vram_addr));
    end

    int passed = 0, total = 0, failed = 0;
    logic [7:0] exp_line [64];
    int b0, l0, c0;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int eff_row(input int raw, input int s);
`ifdef VRAM_TEXT_FETCH_SCROLL_EN
        return (raw + ((s < ROWS) ? s : 0)) % ROWS;
`else
        return raw;
`endif
    endfunction

    task automatic model_line(input int raw, input int s);
        int er;
        er = eff_row(raw, s);
        for (int c = 0; c < 64; c++)
            exp_line[c] = (c < COLS && raw < ROWS) ? mem[er * COLS + c] : 8'h20;
    endtask

    task automatic lookup(input int c, output int v);
        @(negedge clk); col = 6'(c);
        @(negedge clk); v = int'(char_code);
    endtask

    task automatic sweep(input string tag);
        int bad;
        bad = 0;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk); col = 6'(c);
            @(negedge clk); if (char_code !== exp_line[c]) bad++;
        end
        check(tag, bad, 0);
    endtask

    // Request a row; optionally fire a second request inj_at cycles in.
    task automatic fetch(input int raw, input int s, input int inj_at, input int inj_row);
        int n;
        @(negedge clk);
        addr_q.delete();
        b0 = busy_cnt; l0 = lr_cnt; c0 = cyc;
        line_req = 1'b1; row = 5'(raw);
`ifdef VRAM_TEXT_FETCH_SCROLL_EN
        scroll_row = 5'(s);
`endif
        @(negedge clk); line_req = 1'b0;
        n = 0;
        while (lr_cnt == l0 && n < 200) begin
            line_req = (n == inj_at);
            if (n == inj_at) row = 5'(inj_row);
            @(negedge clk); n++;
        end
        line_req = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic verify(input string tag, input int raw, input int s);
        int bad, er;
        er = eff_row(raw, s);
        check({tag, "_lr_cnt"}, lr_cnt - l0, 1);
        check({tag, "_busy_len"}, busy_cnt - b0, COLS + 1);
        check({tag, "_lr_cycle"}, lr_cyc - c0, COLS + 2);
        if (raw < ROWS) begin
            check({tag, "_ce_cnt"}, addr_q.size(), COLS);
            if (addr_q.size() == COLS) begin
                check({tag, "_addr0"}, addr_q[0], er * COLS);
                bad = 0;
                for (int k = 0; k < COLS; k++) if (addr_q[k] != er * COLS + k) bad++;
                check({tag, "_addr_seq"}, bad, 0);
            end
        end else begin
            check({tag, "_ce_cnt"}, addr_q.size(), 0);
            check({tag, "_addr_hold0"}, int'(vram_addr), 0);
        end
        model_line(raw, s);
        sweep({tag, "_buf"});
    endtask

    initial begin
        int v, r, s;
        for (int a = 0; a < 1024; a++) mem[a] = 8'(a);
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_ce", int'(vram_ce), 0);
        check("rst_addr", int'(vram_addr), 0);
        check("rst_char", int'(char_code), 'h20);
        reset = 1'b0;
        for (int c = 0; c < 64; c++) exp_line[c] = 8'h20;
        sweep("rst_buf");
        check("idle_busy", int'(busy), 0);
        check("idle_ce", int'(vram_ce), 0);

        fetch(2, 0, -1, 0);
        verify("row2", 2, 0);
        lookup(0, v);  check("row2_col0", v, 'h78);
        lookup(59, v); check("row2_col59", v, 'hB3);
        lookup(60, v); check("row2_col60", v, 'h20);

        fetch(16, 0, -1, 0);
        verify("row16", 16, 0);
        check("row16_last", addr_q[addr_q.size()-1], 1019);
        lookup(5, v); check("row16_col5", v, 'hC5);

        fetch(17, 0, -1, 0);
        verify("row17", 17, 0);
        fetch(31, 0, -1, 0);
        verify("row31", 31, 0);

        fetch(2, 0, 10, 3);
        verify("busyreq", 2, 0);

        // Reset mid-fetch: buffer currently holds row 2.
        @(negedge clk);
        l0 = lr_cnt;
        line_req = 1'b1; row = 5'd16;
        @(negedge clk); line_req = 1'b0;
        repeat (29) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_ce", int'(vram_ce), 0);
        check("abort_char", int'(char_code), 'h20);
        @(negedge clk); reset = 1'b0;
        repeat (70) @(negedge clk);
        check("abort_no_lr", lr_cnt - l0, 0);
        lookup(0, v); check("abort_col0", v, 'h20);
        for (int c = 0; c < 64; c++) exp_line[c] = 8'h20;
        sweep("abort_buf");

`ifdef VRAM_TEXT_FETCH_SCROLL_EN
        for (int a = 0; a < 1024; a++) mem[a] = 8'(a);
        fetch(14, 5, -1, 0);
        verify("scroll5", 14, 5);
        check("scroll5_first", addr_q.size() > 0 ? addr_q[0] : -1, 120);
        fetch(4, 20, -1, 0);
        verify("scroll20", 4, 20);
        check("scroll20_first", addr_q.size() > 0 ? addr_q[0] : -1, 240);
`endif

        for (int a = 0; a < 1024; a++) mem[a] = 8'($urandom);
        for (int t = 0; t < 8; t++) begin
            r = int'($urandom_range(0, 20));
            s = int'($urandom_range(0, 31));
            fetch(r, s, -1, 0);
            verify($sformatf("rnd%0d_r%0d_s%0d", t, r, s), r, s);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
